// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode/funct constants, control encodings and the control bundle type
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JR     = 3'd3,
        PC_ILLOP  = 3'd4,
        PC_XADR   = 3'd5
    } pc_src_e;

    typedef enum logic [1:0] {
        DST_RD = 2'd0,
        DST_RT = 2'd1,
        DST_RA = 2'd2,
        DST_K0 = 2'd3
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } mem_to_reg_e;

    typedef struct packed {
        pc_src_e     pc_src;
        logic        reg_write;
        reg_dst_e    reg_dst;
        logic        mem_read;
        logic        mem_write;
        mem_to_reg_e mem_to_reg;
        logic        alu_src1;
        logic        alu_src2;
        logic        ext_op;
        logic        lu_op;
        logic        sign;
        logic [5:0]  alu_fun;
        logic        irq_taken;
        logic [2:0]  irq_id;
        logic        exc_illop;
    } ctrl_bundle_t;

    // Interrupt entry and illegal-op exception both save PC into $k0 and vector away.
    function automatic ctrl_bundle_t trap_bundle(input pc_src_e vec);
        ctrl_bundle_t b;
        b            = '0;
        b.pc_src     = vec;
        b.reg_write  = 1'b1;
        b.reg_dst    = DST_K0;
        b.mem_to_reg = WB_PC;
        return b;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational OpCode/Funct to control bundle decoder with illegal flag
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]   OpCode,
    input  logic [5:0]   Funct,
    output ctrl_bundle_t bundle,
    output logic         illegal
);

    always_comb begin
        bundle  = '0;
        illegal = 1'b0;
        case (OpCode)
            OP_RTYPE: begin
                bundle.reg_write = 1'b1;
                case (Funct)
                    FN_ADD:  begin bundle.sign = 1'b1; bundle.alu_fun = ALU_ADD; end
                    FN_ADDU: bundle.alu_fun = ALU_ADD;
                    FN_SUB:  begin bundle.sign = 1'b1; bundle.alu_fun = ALU_SUB; end
                    FN_SUBU: bundle.alu_fun = ALU_SUB;
                    FN_AND:  bundle.alu_fun = ALU_AND;
                    FN_OR:   bundle.alu_fun = ALU_OR;
                    FN_XOR:  bundle.alu_fun = ALU_XOR;
                    FN_NOR:  bundle.alu_fun = ALU_NOR;
                    FN_SLL:  begin bundle.alu_src1 = 1'b1; bundle.alu_fun = ALU_SLL; end
                    FN_SRL:  begin bundle.alu_src1 = 1'b1; bundle.alu_fun = ALU_SRL; end
                    FN_SRA:  begin bundle.alu_src1 = 1'b1; bundle.alu_fun = ALU_SRA; end
                    FN_SLT:  begin bundle.sign = 1'b1; bundle.alu_fun = ALU_LT; end
                    FN_SLTU: bundle.alu_fun = ALU_LT;
                    FN_JR:   begin bundle.reg_write = 1'b0; bundle.pc_src = PC_JR; end
                    FN_JALR: begin bundle.pc_src = PC_JR; bundle.mem_to_reg = WB_PC; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                bundle.reg_write  = 1'b1;
                bundle.reg_dst    = DST_RT;
                bundle.mem_read   = 1'b1;
                bundle.mem_to_reg = WB_MEM;
                bundle.alu_src2   = 1'b1;
                bundle.ext_op     = 1'b1;
            end
            OP_SW: begin
                bundle.mem_write = 1'b1;
                bundle.alu_src2  = 1'b1;
                bundle.ext_op    = 1'b1;
            end
            OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: begin
                bundle.reg_write = 1'b1;
                bundle.reg_dst   = DST_RT;
                bundle.alu_src2  = 1'b1;
                bundle.lu_op     = (OpCode == OP_LUI);
                bundle.ext_op    = (OpCode != OP_LUI) && (OpCode != OP_ANDI);
                bundle.sign      = (OpCode == OP_ADDI) || (OpCode == OP_SLTI);
                case (OpCode)
                    OP_ANDI:           bundle.alu_fun = ALU_AND;
                    OP_SLTI, OP_SLTIU: bundle.alu_fun = ALU_LT;
                    default:           bundle.alu_fun = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: begin
                bundle.pc_src = PC_BRANCH;
                bundle.ext_op = 1'b1;
                case (OpCode)
                    OP_BEQ:  bundle.alu_fun = ALU_EQ;
                    OP_BNE:  bundle.alu_fun = ALU_NEQ;
                    OP_BLEZ: bundle.alu_fun = ALU_LEZ;
                    OP_BGTZ: bundle.alu_fun = ALU_GTZ;
                    default: bundle.alu_fun = ALU_LTZ;
                endcase
            end
            OP_J:   bundle.pc_src = PC_JUMP;
            OP_JAL: begin
                bundle.pc_src     = PC_JUMP;
                bundle.reg_write  = 1'b1;
                bundle.reg_dst    = DST_RA;
                bundle.mem_to_reg = WB_PC;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            bundle = '0;
        end
    end

endmodule

// File: rtl/control_pipe_irq.sv
// rtl/control_pipe_irq.sv - ID/EX control register with decode, interrupt entry and illegal-op exception
module control_pipe_irq
    import cpu_ctrl_pkg::*;
#(
    parameter int IRQ_N           = 4,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             PC_31,
    input  logic [IRQ_N-1:0] irq,
    input  logic [IRQ_N-1:0] irq_mask,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [2:0]       PCSrc,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrc1,
    output logic             ALUSrc2,
    output logic             ExtOp,
    output logic             LuOp,
    output logic             Sign,
    output logic [5:0]       ALUFun,
    output logic             irq_taken,
    output logic [2:0]       irq_id,
    output logic             exc_illop,
    output logic [IRQ_N-1:0] irq_pending
);

    logic [IRQ_SYNC_STAGES-1:0][IRQ_N-1:0] sync_q, sync_d;
    logic [IRQ_N-1:0] sync_prev_q, sync_prev_d;
    logic [IRQ_N-1:0] pending_q, pending_d;
    logic [IRQ_N-1:0] irq_rise, irq_ready;
    logic             out_valid_q, out_valid_d;
    ctrl_bundle_t     bundle_q, bundle_d, dec_bundle, irq_bundle, exc_bundle;
    logic             dec_illegal, transfer, take_irq;
    logic [2:0]       take_id;

    ctrl_decode u_decode (
        .OpCode  (OpCode),
        .Funct   (Funct),
        .bundle  (dec_bundle),
        .illegal (dec_illegal)
    );

    assign in_ready  = ~stall & ~flush;
    assign transfer  = in_valid & in_ready;
    assign irq_rise  = sync_q[IRQ_SYNC_STAGES-1] & ~sync_prev_q;
    assign irq_ready = pending_q & irq_mask;
    assign take_irq  = ~PC_31 & (|irq_ready);

    always_comb begin
        sync_d[0] = irq;
        for (int s = 1; s < IRQ_SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_prev_d = sync_q[IRQ_SYNC_STAGES-1];
    end

    // Fixed priority: scanning downwards leaves the lowest ready index.
    always_comb begin
        take_id = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (irq_ready[i]) begin
                take_id = 3'(i);
            end
        end
    end

    always_comb begin
        irq_bundle           = trap_bundle(PC_ILLOP);
        irq_bundle.irq_taken = 1'b1;
        irq_bundle.irq_id    = take_id;
        exc_bundle           = trap_bundle(PC_XADR);
        exc_bundle.exc_illop = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            if (!in_valid) begin
                bundle_d = '0;
            end else if (take_irq) begin
                bundle_d = irq_bundle;
            end else if (dec_illegal) begin
                bundle_d = exc_bundle;
            end else begin
                bundle_d = dec_bundle;
            end
        end
    end

    // A flushed interrupt entry re-arms its line; a fresh edge always wins over a clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < IRQ_N; i++) begin
            if (transfer && take_irq && (take_id == 3'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (flush && out_valid_q && bundle_q.irq_taken && (bundle_q.irq_id == 3'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
        pending_d = pending_d | irq_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign PCSrc       = bundle_q.pc_src;
    assign RegWrite    = bundle_q.reg_write;
    assign RegDst      = bundle_q.reg_dst;
    assign MemRead     = bundle_q.mem_read;
    assign MemWrite    = bundle_q.mem_write;
    assign MemtoReg    = bundle_q.mem_to_reg;
    assign ALUSrc1     = bundle_q.alu_src1;
    assign ALUSrc2     = bundle_q.alu_src2;
    assign ExtOp       = bundle_q.ext_op;
    assign LuOp        = bundle_q.lu_op;
    assign Sign        = bundle_q.sign;
    assign ALUFun      = bundle_q.alu_fun;
    assign irq_taken   = bundle_q.irq_taken;
    assign irq_id      = bundle_q.irq_id;
    assign exc_illop   = bundle_q.exc_illop;
    assign irq_pending = pending_q;

endmodule

// File: tb/tb_control_pipe_irq.sv
// tb/tb_control_pipe_irq.sv - directed table-driven bench for control_pipe_irq
module tb_control_pipe_irq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] OpCode = '0;
    logic [5:0] Funct = '0;
    logic       PC_31 = 1'b0;
    logic [3:0] irq = '0;
    logic [3:0] irq_mask = 4'b1111;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [2:0] PCSrc;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic       MemRead, MemWrite;
    logic [1:0] MemtoReg;
    logic       ALUSrc1, ALUSrc2, ExtOp, LuOp, Sign;
    logic [5:0] ALUFun;
    logic       irq_taken;
    logic [2:0] irq_id;
    logic       exc_illop;
    logic [3:0] irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_pipe_irq #(.IRQ_N(4), .IRQ_SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .OpCode(OpCode), .Funct(Funct), .PC_31(PC_31), .irq(irq), .irq_mask(irq_mask),
        .stall(stall), .flush(flush), .out_valid(out_valid), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ExtOp(ExtOp),
        .LuOp(LuOp), .Sign(Sign), .ALUFun(ALUFun), .irq_taken(irq_taken),
        .irq_id(irq_id), .exc_illop(exc_illop), .irq_pending(irq_pending)
    );

    function automatic logic [25:0] mk(input logic [2:0] pc, input logic rw, input logic [1:0] rd,
                                       input logic mr, input logic mw, input logic [1:0] m2r,
                                       input logic a1, input logic a2, input logic ex, input logic lu,
                                       input logic sg, input logic [5:0] fun, input logic it,
                                       input logic [2:0] id, input logic ill);
        return {pc, rw, rd, mr, mw, m2r, a1, a2, ex, lu, sg, fun, it, id, ill};
    endfunction

    function automatic logic [25:0] irq_b(input logic [2:0] id);
        return mk(3'd4, 1, 2'd3, 0, 0, 2'd2, 0, 0, 0, 0, 0, 6'h00, 1, id, 0);
    endfunction

    logic [25:0] exc_b;
    logic [25:0] zero_b;

    function automatic logic [25:0] dut_b();
        return {PCSrc, RegWrite, RegDst, MemRead, MemWrite, MemtoReg, ALUSrc1, ALUSrc2,
                ExtOp, LuOp, Sign, ALUFun, irq_taken, irq_id, exc_illop};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic v, input logic [5:0] op, input logic [5:0] fn);
        in_valid = v;
        OpCode   = op;
        Funct    = fn;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        exc_b  = mk(3'd5, 1, 2'd3, 0, 0, 2'd2, 0, 0, 0, 0, 0, 6'h00, 0, 3'd0, 1);
        zero_b = '0;

        vecs.push_back('{"lw",    6'h23, 6'h00, mk(0,1,1,1,0,1,0,1,1,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"sw",    6'h2b, 6'h00, mk(0,0,0,0,1,0,0,1,1,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"lui",   6'h0f, 6'h00, mk(0,1,1,0,0,0,0,1,0,1,0,6'b000000,0,0,0)});
        vecs.push_back('{"addi",  6'h08, 6'h00, mk(0,1,1,0,0,0,0,1,1,0,1,6'b000000,0,0,0)});
        vecs.push_back('{"addiu", 6'h09, 6'h00, mk(0,1,1,0,0,0,0,1,1,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"andi",  6'h0c, 6'h00, mk(0,1,1,0,0,0,0,1,0,0,0,6'b011000,0,0,0)});
        vecs.push_back('{"slti",  6'h0a, 6'h00, mk(0,1,1,0,0,0,0,1,1,0,1,6'b110101,0,0,0)});
        vecs.push_back('{"sltiu", 6'h0b, 6'h00, mk(0,1,1,0,0,0,0,1,1,0,0,6'b110101,0,0,0)});
        vecs.push_back('{"add",   6'h00, 6'h20, mk(0,1,0,0,0,0,0,0,0,0,1,6'b000000,0,0,0)});
        vecs.push_back('{"subu",  6'h00, 6'h23, mk(0,1,0,0,0,0,0,0,0,0,0,6'b000001,0,0,0)});
        vecs.push_back('{"or",    6'h00, 6'h25, mk(0,1,0,0,0,0,0,0,0,0,0,6'b011110,0,0,0)});
        vecs.push_back('{"xor",   6'h00, 6'h26, mk(0,1,0,0,0,0,0,0,0,0,0,6'b010110,0,0,0)});
        vecs.push_back('{"nor",   6'h00, 6'h27, mk(0,1,0,0,0,0,0,0,0,0,0,6'b010001,0,0,0)});
        vecs.push_back('{"sll",   6'h00, 6'h00, mk(0,1,0,0,0,0,1,0,0,0,0,6'b100000,0,0,0)});
        vecs.push_back('{"sra",   6'h00, 6'h03, mk(0,1,0,0,0,0,1,0,0,0,0,6'b100011,0,0,0)});
        vecs.push_back('{"slt",   6'h00, 6'h2a, mk(0,1,0,0,0,0,0,0,0,0,1,6'b110101,0,0,0)});
        vecs.push_back('{"sltu",  6'h00, 6'h2b, mk(0,1,0,0,0,0,0,0,0,0,0,6'b110101,0,0,0)});
        vecs.push_back('{"beq",   6'h04, 6'h00, mk(1,0,0,0,0,0,0,0,1,0,0,6'b110011,0,0,0)});
        vecs.push_back('{"bne",   6'h05, 6'h00, mk(1,0,0,0,0,0,0,0,1,0,0,6'b110001,0,0,0)});
        vecs.push_back('{"blez",  6'h06, 6'h00, mk(1,0,0,0,0,0,0,0,1,0,0,6'b111101,0,0,0)});
        vecs.push_back('{"bgtz",  6'h07, 6'h00, mk(1,0,0,0,0,0,0,0,1,0,0,6'b111111,0,0,0)});
        vecs.push_back('{"bltz",  6'h01, 6'h00, mk(1,0,0,0,0,0,0,0,1,0,0,6'b111011,0,0,0)});
        vecs.push_back('{"j",     6'h02, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"jal",   6'h03, 6'h00, mk(2,1,2,0,0,2,0,0,0,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"jr",    6'h00, 6'h08, mk(3,0,0,0,0,0,0,0,0,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"jalr",  6'h00, 6'h09, mk(3,1,0,0,0,2,0,0,0,0,0,6'b000000,0,0,0)});
        vecs.push_back('{"ill_fn30", 6'h00, 6'h30, exc_b});
        vecs.push_back('{"ill_fn01", 6'h00, 6'h01, exc_b});
        vecs.push_back('{"ill_op3f", 6'h3f, 6'h00, exc_b});

        step();
        step();
        chk("reset_valid", out_valid, 0);
        chk("reset_bundle", dut_b(), zero_b);
        chk("reset_pending", irq_pending, 0);
        reset = 1'b0;
        step();
        chk("post_reset_idle", out_valid, 0);

        foreach (vecs[i]) begin
            present(1, vecs[i].op, vecs[i].fn);
            step();
            chk({"valid_", vecs[i].name}, out_valid, 1);
            chk({"bundle_", vecs[i].name}, dut_b(), vecs[i].exp);
        end

        present(1, 6'h00, 6'h30);
        step();
        chk("exc_before_stall", dut_b(), exc_b);
        stall = 1'b1;
        present(1, 6'h23, 6'h00);
        #1;
        chk("in_ready_stall", in_ready, 0);
        step();
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_bundle", dut_b(), exc_b);
        stall = 1'b0;
        flush = 1'b1;
        #1;
        chk("in_ready_flush", in_ready, 0);
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_bundle", dut_b(), zero_b);
        flush = 1'b0;
        present(0, 6'h23, 6'h00);
        step();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_bundle", dut_b(), zero_b);

        irq = 4'b0110;
        step();
        chk("sync_pend_1", irq_pending, 4'b0000);
        step();
        chk("sync_pend_2", irq_pending, 4'b0000);
        step();
        chk("sync_pend_3", irq_pending, 4'b0110);
        present(1, 6'h00, 6'h20);
        step();
        chk("irq_entry_1", dut_b(), irq_b(3'd1));
        chk("irq_pend_after_1", irq_pending, 4'b0100);
        step();
        chk("irq_entry_2", dut_b(), irq_b(3'd2));
        chk("irq_pend_after_2", irq_pending, 4'b0000);
        irq = 4'b0000;
        step();
        chk("irq_resume_add", dut_b(), mk(0,1,0,0,0,0,0,0,0,0,1,6'b000000,0,0,0));

        present(0, 6'h23, 6'h00);
        irq = 4'b0001;
        repeat (3) step();
        irq = 4'b0000;
        chk("k_pend_set", irq_pending, 4'b0001);
        PC_31 = 1'b1;
        present(1, 6'h23, 6'h00);
        step();
        chk("k_defer_lw", dut_b(), vecs[0].exp);
        chk("k_defer_pend", irq_pending, 4'b0001);
        PC_31 = 1'b0;
        step();
        chk("k_entry", dut_b(), irq_b(3'd0));
        chk("k_entry_pend", irq_pending, 4'b0000);

        present(0, 6'h23, 6'h00);
        irq = 4'b1000;
        irq_mask = 4'b0111;
        repeat (3) step();
        irq = 4'b0000;
        present(1, 6'h23, 6'h00);
        step();
        chk("mask_no_entry", dut_b(), vecs[0].exp);
        chk("mask_pend_kept", irq_pending, 4'b1000);
        irq_mask = 4'b1111;
        step();
        chk("unmask_entry", dut_b(), irq_b(3'd3));
        chk("unmask_pend", irq_pending, 4'b0000);

        present(0, 6'h00, 6'h20);
        irq = 4'b0100;
        repeat (3) step();
        irq = 4'b0000;
        present(1, 6'h00, 6'h20);
        step();
        chk("fl_entry", dut_b(), irq_b(3'd2));
        chk("fl_entry_pend", irq_pending, 4'b0000);
        flush = 1'b1;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_rearm_pend", irq_pending, 4'b0100);
        flush = 1'b0;
        present(1, 6'h00, 6'h30);
        step();
        chk("fl_retake_over_exc", dut_b(), irq_b(3'd2));
        chk("fl_retake_pend", irq_pending, 4'b0000);

        present(0, 6'h00, 6'h20);
        irq = 4'b0001;
        step();
        irq = 4'b0000;
        step();
        irq = 4'b0001;
        step();
        chk("sw_first_pend", irq_pending, 4'b0001);
        step();
        present(1, 6'h00, 6'h20);
        step();
        chk("sw_entry", dut_b(), irq_b(3'd0));
        chk("sw_set_wins", irq_pending, 4'b0001);
        irq = 4'b0000;
        step();
        chk("sw_second_entry", dut_b(), irq_b(3'd0));
        chk("sw_second_pend", irq_pending, 4'b0000);

        present(0, 6'h23, 6'h00);
        irq = 4'b0010;
        repeat (3) step();
        irq = 4'b0000;
        PC_31 = 1'b1;
        present(1, 6'h23, 6'h00);
        step();
        chk("mr_valid_before", out_valid, 1);
        chk("mr_pend_before", irq_pending, 4'b0010);
        present(0, 6'h23, 6'h00);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_async_valid", out_valid, 0);
        chk("mr_async_bundle", dut_b(), zero_b);
        chk("mr_async_pend", irq_pending, 4'b0000);
        step();
        reset = 1'b0;
        PC_31 = 1'b0;
        step();
        chk("mr_after_release", out_valid, 0);
        step();
        chk("mr_after_release_2", out_valid, 0);
        chk("mr_pend_after", irq_pending, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_pipe_irq.md
Name: control_pipe_irq

Overview:
Registered successor to the single-cycle Control decoder. It decodes OpCode/Funct into the full datapath control bundle and registers the bundle as the ID/EX control stage, with a valid/stall/flush handshake. It adds multi-line interrupt handling: synchronisers, pending latches, a mask and fixed priority. It also raises an illegal-instruction exception. It sits between the IF/ID register and the execute stage of the pipelined CPU.

Parameters:
IRQ_N, 4, number of external interrupt lines (1..8)
IRQ_SYNC_STAGES, 2, synchroniser flops per irq line (>=2)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  ~stall & ~flush; transfer = in_valid & in_ready
OpCode  in  6  instruction[31:26]
Funct  in  6  instruction[5:0]
PC_31  in  1  kernel mode; 1 blocks interrupt entry
irq  in  IRQ_N  asynchronous interrupt requests, level
irq_mask  in  IRQ_N  1 = line enabled
stall  in  1  hazard unit: hold the output register
flush  in  1  branch/exception kill: insert a bubble
out_valid  out  1  bundle is valid
PCSrc  out  3  0 PC+4, 1 branch, 2 J, 3 JR, 4 ILLOP (interrupt), 5 XADR (exception)
RegWrite  out  1  register file write enable
RegDst  out  2  0 rd, 1 rt, 2 $ra, 3 $k0
MemRead, MemWrite  out  1 each  memory control
MemtoReg  out  2  0 ALU, 1 memory, 2 PC
ALUSrc1, ALUSrc2, ExtOp, LuOp, Sign  out  1 each  datapath selects
ALUFun  out  6  ALU function code
irq_taken  out  1  bundle is an interrupt entry
irq_id  out  3  index of the serviced line
exc_illop  out  1  bundle is an undefined-instruction exception
irq_pending  out  IRQ_N  pending latches, visible for debug

Behaviour:
- Reset (asynchronous): every output, the pending latches and the synchronisers go to 0.
- Latency is one cycle from a transfer to the bundle on the outputs.
- Per edge, priority is flush > stall > transfer:
  - flush: out_valid<=0 and the bundle is zeroed.
  - else stall: all outputs hold.
  - else: out_valid<=in_valid; bundle<=decode if in_valid, otherwise zeros.
- Decoding covers lw, sw, lui, add, addu, sub, subu, addi, addiu, and, or, xor, nor, andi, sll, srl, sra, slt, sltu, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal, jr, jalr. Encodings are the existing single-cycle ones.
- Any other OpCode/Funct raises the exception bundle: PCSrc=5, RegWrite=1, RegDst=3, MemtoReg=2, exc_illop=1, all else 0.
- Interrupt path:
  - Each irq bit passes through IRQ_SYNC_STAGES flops, then rising-edge detection.
  - A detected edge sets pending[i] one cycle later.
  - Total latency from irq rise to pending is IRQ_SYNC_STAGES+1 cycles.
- Interrupt entry happens on a transfer when PC_31==0 and |(pending & irq_mask).
  - The lowest set index wins.
  - Output bundle: PCSrc=4, RegWrite=1, RegDst=3, MemtoReg=2, irq_taken=1, irq_id=index, all else 0.
  - The instruction being presented is replaced, not executed.
  - pending[index] clears at the same edge.
- Interrupt entry beats the exception when both apply.
- If a new edge and a clear hit the same line in the same cycle, the set wins.
- If a registered interrupt bundle is flushed, pending[irq_id] is re-set at that edge so the interrupt is not lost.
- Masked lines stay pending until unmasked. PC_31==1 defers entry and never drops pending bits.
- irq_mask and PC_31 are sampled only at transfer edges.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - OpCode/Funct constants
  - PCSrc, RegDst and MemtoReg encodings
  - ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111
- Sub-module ctrl_decode: purely combinational OpCode/Funct to bundle plus illegal flag. The top level owns the pipeline register, interrupt logic and priority.

Test Plan:
- Reset mid-stream: assert reset with out_valid=1 -> all outputs 0 immediately (asynchronous); no bundle appears after release until a transfer.
- lw presented for one cycle (OpCode=0x23) -> next cycle: out_valid=1, MemRead=1, RegWrite=1, RegDst=1, MemtoReg=1, ALUSrc2=1, ExtOp=1, ALUFun=000000. Then jal (OpCode=0x03) -> PCSrc=2, RegDst=2, MemtoReg=2.
- OpCode=0, Funct=0x30 -> exc_illop=1, PCSrc=5, RegDst=3. With stall=1 the next cycle -> bundle held, in_ready=0. With flush=1 -> out_valid=0.
- irq=4'b0110, mask=4'b1111, PC_31=0 -> pending=0110 after 3 cycles. Next transfer gives irq_taken=1, irq_id=1, PCSrc=4, pending=0100. Following transfer gives irq_id=2.
- pending=0001 with PC_31=1 -> normal decode continues and pending stays set. After PC_31=0 -> entry on the next transfer.
- Interrupt bundle flushed the cycle after entry -> pending[irq_id] re-asserted; the interrupt is re-taken on the next transfer.
